// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
// Registers one EX op, runs its load/store on the dmem req/gnt/rvalid bus,
// aligns/extends load data and hands the result to WB under valid/ready.
// Ports: clk/rst; ex_* (EX payload + ex_valid/ex_ready); dmem_* (data bus);
// wb_* + MemOut (WB payload, wb_valid/wb_ready); mem_raw_* (RAW forward).
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [INST_W-1:0] ex_inst,
  input  logic [XLEN-1:0]   ex_ALUres,
  input  logic [XLEN-1:0]   ex_R_rs2,
  input  logic              ex_MemRd,
  input  logic              ex_MemWr,
  input  logic [2:0]        ex_MemOP,
  input  logic [1:0]        ex_RegSrc,
  input  logic              ex_RegWr,
  input  logic              ex_isecall,
  input  logic              ex_ismret,
  input  logic              ex_iscsr,
  input  logic [XLEN-1:0]   ex_R_rs1,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_pc,
  output logic [INST_W-1:0] wb_inst,
  output logic [XLEN-1:0]   wb_ALUres,
  output logic [1:0]        wb_RegSrc,
  output logic              wb_RegWr,
  output logic              wb_isecall,
  output logic              wb_ismret,
  output logic              wb_iscsr,
  output logic [XLEN-1:0]   wb_R_rs1,
  output logic [XLEN-1:0]   MemOut,
  output logic [4:0]        mem_raw_rd,
  output logic              mem_raw_data_valid,
  output logic [XLEN-1:0]   mem_raw_Wdata
);

  typedef enum logic [1:0] {
    IDLE, REQ, RESP, DONE
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   rs2;
  logic              mem_rd;
  logic              mem_wr;
  logic [2:0]        mem_op;
  logic              m_valid;
  logic              accept;
  logic [2:0]        lane;
  logic [XLEN-1:0]   rsh;
  logic [XLEN-1:0]   load_ext;

  assign m_valid  = (state != IDLE);
  assign wb_valid = (state == DONE);
  assign ex_ready = ~m_valid | (wb_valid & wb_ready);
  assign accept   = ex_valid & ex_ready;

  // Byte lane: address bits below the access size are ignored.
  always_comb begin
    lane = 3'd0;
    unique case (mem_op[1:0])
      2'b00:   lane = wb_ALUres[2:0];
      2'b01:   lane = {wb_ALUres[2:1], 1'b0};
      2'b10:   lane = {wb_ALUres[2], 2'b00};
      default: lane = 3'd0;
    endcase
  end

  always_comb begin
    dmem_wmask = 8'hFF;
    unique case (mem_op[1:0])
      2'b00:   dmem_wmask = 8'h01 << lane;
      2'b01:   dmem_wmask = 8'h03 << lane;
      2'b10:   dmem_wmask = 8'h0F << lane;
      default: dmem_wmask = 8'hFF;
    endcase
  end

  assign rsh = dmem_rdata >> {lane, 3'b000};

  // MemOP 111 falls through to the full-width (ld) case.
  always_comb begin
    load_ext = rsh;
    case (mem_op)
      3'b000:  load_ext = {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      3'b010:  load_ext = {{(XLEN-32){rsh[31]}}, rsh[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rsh[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rsh[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, rsh[31:0]};
      default: load_ext = rsh;
    endcase
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = mem_wr & ~mem_rd;
  assign dmem_addr  = {wb_ALUres[XLEN-1:3], 3'b000};
  assign dmem_wdata = rs2 << {lane, 3'b000};

  assign mem_raw_rd         = wb_inst[11:7];
  assign mem_raw_data_valid = m_valid & wb_RegWr &
                              (~mem_rd | (state == DONE));
  assign mem_raw_Wdata      = (wb_RegSrc == 2'd1) ? MemOut : wb_ALUres;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wb_pc      <= '0;
      wb_inst    <= '0;
      wb_ALUres  <= '0;
      rs2        <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_op     <= 3'd0;
      wb_RegSrc  <= 2'd0;
      wb_RegWr   <= 1'b0;
      wb_isecall <= 1'b0;
      wb_ismret  <= 1'b0;
      wb_iscsr   <= 1'b0;
      wb_R_rs1   <= '0;
      MemOut     <= '0;
    end else begin
      unique case (state)
        REQ:  if (dmem_gnt) state <= mem_rd ? RESP : DONE;
        RESP: if (dmem_rvalid) begin
                MemOut <= load_ext;
                state  <= DONE;
              end
        DONE: if (wb_ready) state <= IDLE;
        default: ;
      endcase
      // Accept wins over the DONE->IDLE retire so back-to-back has no bubble.
      if (accept) begin
        wb_pc      <= ex_pc;
        wb_inst    <= ex_inst;
        wb_ALUres  <= ex_ALUres;
        rs2        <= ex_R_rs2;
        mem_rd     <= ex_MemRd;
        mem_wr     <= ex_MemWr;
        mem_op     <= ex_MemOP;
        wb_RegSrc  <= ex_RegSrc;
        wb_RegWr   <= ex_RegWr;
        wb_isecall <= ex_isecall;
        wb_ismret  <= ex_ismret;
        wb_iscsr   <= ex_iscsr;
        wb_R_rs1   <= ex_R_rs1;
        MemOut     <= '0;
        state      <= (ex_MemRd | ex_MemWr) ? REQ : DONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage.
// Hand-computed vectors for load/store alignment, handshakes, stalls, reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_pc, ex_ALUres, ex_R_rs2, ex_R_rs1;
  logic [31:0] ex_inst;
  logic        ex_MemRd, ex_MemWr;
  logic [2:0]  ex_MemOP;
  logic [1:0]  ex_RegSrc;
  logic        ex_RegWr, ex_isecall, ex_ismret, ex_iscsr;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_pc, wb_ALUres, wb_R_rs1, MemOut;
  logic [31:0] wb_inst;
  logic [1:0]  wb_RegSrc;
  logic        wb_RegWr, wb_isecall, wb_ismret, wb_iscsr;
  logic [4:0]  mem_raw_rd;
  logic        mem_raw_data_valid;
  logic [63:0] mem_raw_Wdata;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_ALUres(ex_ALUres), .ex_R_rs2(ex_R_rs2),
    .ex_MemRd(ex_MemRd), .ex_MemWr(ex_MemWr),
    .ex_MemOP(ex_MemOP), .ex_RegSrc(ex_RegSrc),
    .ex_RegWr(ex_RegWr), .ex_isecall(ex_isecall),
    .ex_ismret(ex_ismret), .ex_iscsr(ex_iscsr),
    .ex_R_rs1(ex_R_rs1),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_ALUres(wb_ALUres), .wb_RegSrc(wb_RegSrc),
    .wb_RegWr(wb_RegWr), .wb_isecall(wb_isecall),
    .wb_ismret(wb_ismret), .wb_iscsr(wb_iscsr),
    .wb_R_rs1(wb_R_rs1), .MemOut(MemOut),
    .mem_raw_rd(mem_raw_rd),
    .mem_raw_data_valid(mem_raw_data_valid),
    .mem_raw_Wdata(mem_raw_Wdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rd, input logic wr,
                        input logic [2:0] op,
                        input logic [63:0] alu,
                        input logic [63:0] rs2,
                        input logic [31:0] inst,
                        input logic [1:0] rsrc,
                        input logic rwr);
    ex_MemRd  = rd;
    ex_MemWr  = wr;
    ex_MemOP  = op;
    ex_ALUres = alu;
    ex_R_rs2  = rs2;
    ex_inst   = inst;
    ex_RegSrc = rsrc;
    ex_RegWr  = rwr;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [2:0] op,
                       input logic [63:0] alu,
                       input logic [63:0] rs2,
                       input logic [31:0] inst,
                       input logic [1:0] rsrc,
                       input logic rwr);
    set_ex(rd, wr, op, alu, rs2, inst, rsrc, rwr);
    ex_valid = 1'b1;
    chk("ex_ready_at_issue", 64'(ex_ready), 64'd1);
    tick;
    ex_valid = 1'b0;
  endtask

  task automatic wait_wb(input string tag, input int exp_cyc);
    int c = 0;
    while (!wb_valid && c < 20) begin
      tick;
      c++;
    end
    chk(tag, 64'(c), 64'(exp_cyc));
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0;
    ex_pc = 64'h0;
    ex_R_rs1 = 64'h0;
    ex_isecall = 1'b0;
    ex_ismret = 1'b0;
    ex_iscsr = 1'b0;
    set_ex(1'b0, 1'b0, 3'd0, 64'h0, 64'h0, 32'h0, 2'd0, 1'b0);
    wb_ready = 1'b1;
    dmem_gnt = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 64'h0;
    tick;
    tick;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_memout", MemOut, 64'h0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    rst = 1'b0;
    tick;

    // addi x5: no memory access
    ex_pc = 64'h100;
    issue(1'b0, 1'b0, 3'd0, 64'h5, 64'h0, 32'h00500293, 2'd0, 1'b1);
    wait_wb("addi_lat", 0);
    chk("addi_memout", MemOut, 64'h0);
    chk("addi_req", 64'(dmem_req), 64'd0);
    chk("addi_alures", wb_ALUres, 64'h5);
    chk("addi_pc", wb_pc, 64'h100);
    chk("addi_raw_rd", 64'(mem_raw_rd), 64'd5);
    chk("addi_raw_dv", 64'(mem_raw_data_valid), 64'd1);
    chk("addi_raw_wd", mem_raw_Wdata, 64'h5);
    tick;
    chk("addi_retire", 64'(wb_valid), 64'd0);

    // lb / lbu at 0x1003, byte 3 = 0x80
    dmem_rdata = 64'h0000_0000_8000_0000;
    issue(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 32'h00000300, 2'd1, 1'b1);
    chk("lb_req", 64'(dmem_req), 64'd1);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_we", 64'(dmem_we), 64'd0);
    chk("lb_raw_dv_pend", 64'(mem_raw_data_valid), 64'd0);
    wait_wb("lb_lat", 2);
    chk("lb_memout", MemOut, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_raw_dv", 64'(mem_raw_data_valid), 64'd1);
    chk("lb_raw_wd", mem_raw_Wdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick;
    issue(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 32'h00000300, 2'd1, 1'b1);
    wait_wb("lbu_lat", 2);
    chk("lbu_memout", MemOut, 64'h80);
    tick;

    // sh at 0x2006, sb at 0x8005
    issue(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 32'h0, 2'd0, 1'b0);
    chk("sh_addr", dmem_addr, 64'h2000);
    chk("sh_wmask", 64'(dmem_wmask), 64'hC0);
    chk("sh_wdata", dmem_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we", 64'(dmem_we), 64'd1);
    wait_wb("sh_lat", 1);
    chk("sh_memout", MemOut, 64'h0);
    tick;
    issue(1'b0, 1'b1, 3'b000, 64'h8005, 64'hAA, 32'h0, 2'd0, 1'b0);
    chk("sb_wmask", 64'(dmem_wmask), 64'h20);
    chk("sb_wdata", dmem_wdata, 64'h0000_AA00_0000_0000);
    wait_wb("sb_lat", 1);
    tick;

    // sw at 0x3004 with gnt held low 3 cycles
    dmem_gnt = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 64'h3004, 64'h1122_3344, 32'h0, 2'd0, 1'b0);
    chk("sw_wdata", dmem_wdata, 64'h1122_3344_0000_0000);
    chk("sw_wmask", 64'(dmem_wmask), 64'hF0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 64'(dmem_req), 64'd1);
      chk("stall_addr", dmem_addr, 64'h3000);
      chk("stall_ex_ready", 64'(ex_ready), 64'd0);
      chk("stall_wb_valid", 64'(wb_valid), 64'd0);
      tick;
    end
    dmem_gnt = 1'b1;
    chk("stall_req_end", 64'(dmem_req), 64'd1);
    tick;
    chk("stall_done", 64'(wb_valid), 64'd1);
    tick;

    // ld at 0x4000, WB back-pressure for 2 cycles, next op stalled
    dmem_rdata = 64'h0123_4567_89AB_CDEF;
    wb_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 32'h00000380, 2'd1, 1'b1);
    wait_wb("ld_lat", 2);
    chk("ld_memout", MemOut, 64'h0123_4567_89AB_CDEF);
    set_ex(1'b0, 1'b0, 3'd0, 64'h7, 64'h0, 32'h00000400, 2'd0, 1'b1);
    ex_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("bp_wb_valid", 64'(wb_valid), 64'd1);
      chk("bp_memout", MemOut, 64'h0123_4567_89AB_CDEF);
      chk("bp_alures", wb_ALUres, 64'h4000);
      chk("bp_ex_ready", 64'(ex_ready), 64'd0);
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(ex_ready), 64'd1);
    tick;
    ex_valid = 1'b0;
    chk("bp_next_valid", 64'(wb_valid), 64'd1);
    chk("bp_next_alures", wb_ALUres, 64'h7);
    chk("bp_next_memout", MemOut, 64'h0);
    tick;

    // back-to-back lw / lhu: no bubble
    dmem_rdata = 64'h8765_4321_CAFE_1234;
    issue(1'b1, 1'b0, 3'b010, 64'h5004, 64'h0, 32'h0, 2'd1, 1'b1);
    wait_wb("lw_lat", 2);
    chk("lw_memout", MemOut, 64'hFFFF_FFFF_8765_4321);
    issue(1'b1, 1'b0, 3'b101, 64'h5002, 64'h0, 32'h0, 2'd1, 1'b1);
    chk("b2b_req", 64'(dmem_req), 64'd1);
    chk("b2b_wb_valid", 64'(wb_valid), 64'd0);
    chk("b2b_addr", dmem_addr, 64'h5000);
    wait_wb("lhu_lat", 2);
    chk("lhu_memout", MemOut, 64'h0000_0000_0000_CAFE);
    tick;

    // MemRd & MemWr with MemOP 111: load, full width
    issue(1'b1, 1'b1, 3'b111, 64'h7008, 64'h0, 32'h0, 2'd1, 1'b1);
    chk("rw_we", 64'(dmem_we), 64'd0);
    wait_wb("rw_lat", 2);
    chk("rw_memout", MemOut, 64'h8765_4321_CAFE_1234);
    tick;

    // reset while waiting in RESP, late rvalid ignored
    dmem_rvalid = 1'b0;
    issue(1'b1, 1'b0, 3'b011, 64'h6000, 64'h0, 32'h0, 2'd1, 1'b1);
    tick;
    chk("resp_req", 64'(dmem_req), 64'd0);
    chk("resp_wb_valid", 64'(wb_valid), 64'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 64'hDEAD;
    chk("mrst_ex_ready", 64'(ex_ready), 64'd1);
    tick;
    chk("mrst_wb_valid", 64'(wb_valid), 64'd0);
    chk("mrst_memout", MemOut, 64'h0);
    chk("mrst_req", 64'(dmem_req), 64'd0);
    tick;
    chk("mrst_wb_valid2", 64'(wb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
